// File: rtl/spram_arbiter.sv
// Two-requester front end for a shared single-port RAM: arbitrates A/B,
// sequences the RAM strobes and captures read data per requester.
module spram_arbiter #(
  parameter int unsigned ADDRWIDTH = 13,
  parameter int unsigned DATAWIDTH = 16,
  parameter bit          PRIO_A    = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_a,
  input  logic                 we_a,
  input  logic [ADDRWIDTH-1:0] addr_a,
  input  logic [DATAWIDTH-1:0] din_a,
  output logic                 ack_a,
  output logic [DATAWIDTH-1:0] dout_a,
  input  logic                 req_b,
  input  logic                 we_b,
  input  logic [ADDRWIDTH-1:0] addr_b,
  input  logic [DATAWIDTH-1:0] din_b,
  output logic                 ack_b,
  output logic [DATAWIDTH-1:0] dout_b,
  output logic                 busy,
  output logic [ADDRWIDTH-1:0] ram_address,
  output logic [DATAWIDTH-1:0] ram_data,
  output logic                 ram_wren,
  input  logic [DATAWIDTH-1:0] ram_q
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  state_t               state_q, state_d;
  logic                 sel_q, sel_d;
  logic                 rd_q, rd_d;
  logic                 last_q, last_d;
  logic                 ack_a_q, ack_a_d;
  logic                 ack_b_q, ack_b_d;
  logic                 busy_q, busy_d;
  logic                 wren_q, wren_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic [DATAWIDTH-1:0] dout_a_q, dout_a_d;
  logic [DATAWIDTH-1:0] dout_b_q, dout_b_d;
  logic                 grant_b;

  // B wins when alone, or on a tie when round-robin and A was served last.
  assign grant_b = req_b & (~req_a | ((PRIO_A == 1'b0) & (last_q == SEL_A)));

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rd_d     = rd_q;
    last_d   = last_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wren_d   = 1'b0;
    ack_a_d  = 1'b0;
    ack_b_d  = 1'b0;
    dout_a_d = dout_a_q;
    dout_b_d = dout_b_q;
    case (state_q)
      S_IDLE: begin
        if (req_a | req_b) begin
          sel_d = grant_b;
          if (grant_b) begin
            addr_d = addr_b;
            data_d = din_b;
            wren_d = we_b;
            rd_d   = ~we_b;
          end else begin
            addr_d = addr_a;
            data_d = din_a;
            wren_d = we_a;
            rd_d   = ~we_a;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // RAM output is valid this cycle; capture it and raise ack for DONE.
        if (rd_q) begin
          if (sel_q == SEL_B) dout_b_d = ram_q;
          else                dout_a_d = ram_q;
        end
        ack_a_d = (sel_q == SEL_A);
        ack_b_d = (sel_q == SEL_B);
        state_d = S_DONE;
      end
      S_DONE: begin
        last_d  = sel_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sel_q    <= SEL_A;
      rd_q     <= 1'b0;
      last_q   <= SEL_B;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      busy_q   <= 1'b0;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      dout_a_q <= '0;
      dout_b_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rd_q     <= rd_d;
      last_q   <= last_d;
      ack_a_q  <= ack_a_d;
      ack_b_q  <= ack_b_d;
      busy_q   <= busy_d;
      wren_q   <= wren_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      dout_a_q <= dout_a_d;
      dout_b_q <= dout_b_d;
    end
  end

  assign ack_a       = ack_a_q;
  assign ack_b       = ack_b_q;
  assign dout_a      = dout_a_q;
  assign dout_b      = dout_b_q;
  assign busy        = busy_q;
  assign ram_address = addr_q;
  assign ram_data    = data_q;
  assign ram_wren    = wren_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: round-robin (dut0) and fixed-priority (dut1) instances,
// each with its own RAM, checked against a transaction-level model.
module tb_spram_arbiter;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 16;
  localparam bit SIDE_A = 1'b0;
  localparam bit SIDE_B = 1'b1;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_a, we_a, req_b, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] din_a, din_b;

  logic          ack_a0, ack_b0, busy0, ram_wren0;
  logic [DW-1:0] dout_a0, dout_b0, ram_data0, ram_q0;
  logic [AW-1:0] ram_address0;
  logic          ack_a1, ack_b1, busy1, ram_wren1;
  logic [DW-1:0] dout_a1, dout_b1, ram_data1, ram_q1;
  logic [AW-1:0] ram_address1;

  logic [DW-1:0] mem0 [0:(1<<AW)-1];
  logic [DW-1:0] mem1 [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [AW-1:0] raddr0, raddr1;
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_val;

  int            wren_cnt0 = 0;
  logic [AW-1:0] wren_addr0;
  logic [DW-1:0] wren_data0;

  int            n_checks = 0;
  int            n_fail = 0;
  // Model state: last read value seen by each requester, and who was served last.
  logic [DW-1:0] exp_a, exp_b;
  bit            last_win;

  always #5 clock = ~clock;

  spram_arbiter #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .PRIO_A(1'b0)) dut0 (
    .clock(clock), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .ack_a(ack_a0), .dout_a(dout_a0),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .ack_b(ack_b0), .dout_b(dout_b0),
    .busy(busy0), .ram_address(ram_address0), .ram_data(ram_data0), .ram_wren(ram_wren0), .ram_q(ram_q0)
  );

  spram_arbiter #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .PRIO_A(1'b1)) dut1 (
    .clock(clock), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .ack_a(ack_a1), .dout_a(dout_a1),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .ack_b(ack_b1), .dout_b(dout_b1),
    .busy(busy1), .ram_address(ram_address1), .ram_data(ram_data1), .ram_wren(ram_wren1), .ram_q(ram_q1)
  );

  // Single-port RAMs: registered address, unregistered output.
  always @(posedge clock) begin
    if (pre_en) begin
      mem0[pre_addr] <= pre_val;
      mem1[pre_addr] <= pre_val;
    end
    if (ram_wren0) mem0[ram_address0] <= ram_data0;
    if (ram_wren1) mem1[ram_address1] <= ram_data1;
    raddr0 <= ram_address0;
    raddr1 <= ram_address1;
  end
  assign ram_q0 = mem0[raddr0];
  assign ram_q1 = mem1[raddr1];

  always @(negedge clock) begin
    if (ram_wren0) begin
      wren_cnt0  <= wren_cnt0 + 1;
      wren_addr0 <= ram_address0;
      wren_data0 <= ram_data0;
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (2) @(negedge clock);
    reset    = 1'b0;
    exp_a    = '0;
    exp_b    = '0;
    last_win = SIDE_B;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    pre_addr   = a;
    pre_val    = v;
    pre_en     = 1'b1;
    ref_mem[a] = v;
    @(negedge clock);
    pre_en = 1'b0;
  endtask

  // Count starts at 'start' (1 when the request was raised this cycle, 0 from an ack cycle).
  task automatic wait_ack(input int inst, input int start, output int cyc, output logic ga, output logic gb);
    cyc = start;
    ga  = 1'b0;
    gb  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      cyc++;
      ga = (inst == 0) ? ack_a0 : ack_a1;
      gb = (inst == 0) ? ack_b0 : ack_b1;
      if (ga || gb) break;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if ({ack_a0, ack_b0, busy0, ram_wren0} !== 4'b0) begin n_fail++; $display("FAIL reset_ctl0: got %b want 0000", {ack_a0, ack_b0, busy0, ram_wren0}); end
    n_checks++; if ({ram_address0, ram_data0} !== '0) begin n_fail++; $display("FAIL reset_ram0: got addr %h data %h want 0", ram_address0, ram_data0); end
    n_checks++; if ({dout_a0, dout_b0} !== '0) begin n_fail++; $display("FAIL reset_dout0: got %h/%h want 0", dout_a0, dout_b0); end
    n_checks++; if ({ack_a1, ack_b1, busy1, ram_wren1, ram_address1, ram_data1, dout_a1, dout_b1} !== '0) begin n_fail++; $display("FAIL reset_dut1: busy %b wren %b addr %h want all 0", busy1, ram_wren1, ram_address1); end
    repeat (3) @(negedge clock);
    n_checks++; if ({ack_a0, ack_b0, busy0, ram_wren0, ack_a1, ack_b1, busy1, ram_wren1} !== 8'b0) begin n_fail++; $display("FAIL idle_quiet: got %b want 0", {ack_a0, ack_b0, busy0, ram_wren0, ack_a1, ack_b1, busy1, ram_wren1}); end
  endtask

  task automatic test_single_read();
    int cyc, w0;
    logic ga, gb;
    preload(13'h0010, 16'hBEEF);
    w0 = wren_cnt0;
    req_a = 1'b1; we_a = 1'b0; addr_a = 13'h0010; din_a = DW'($urandom);
    wait_ack(0, 1, cyc, ga, gb);
    req_a = 1'b0;
    exp_a = ref_mem[13'h0010];
    last_win = SIDE_A;
    n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL rd_latency: got %0d cycles want 4", cyc); end
    n_checks++; if ({ga, gb} !== 2'b10) begin n_fail++; $display("FAIL rd_ack: got %b want 10", {ga, gb}); end
    n_checks++; if (dout_a0 !== exp_a || dout_b0 !== exp_b) begin n_fail++; $display("FAIL rd_dout: got %h/%h want %h/%h", dout_a0, dout_b0, exp_a, exp_b); end
    n_checks++; if (wren_cnt0 !== w0 || busy0 !== 1'b1) begin n_fail++; $display("FAIL rd_wren_busy: wren %0d busy %b want 0 1", wren_cnt0 - w0, busy0); end
    @(negedge clock);
    n_checks++; if ({ack_a0, busy0} !== 2'b00) begin n_fail++; $display("FAIL rd_after: ack/busy %b want 00", {ack_a0, busy0}); end
  endtask

  task automatic test_write_read();
    int cyc, w0;
    logic ga, gb;
    w0 = wren_cnt0;
    req_b = 1'b1; we_b = 1'b1; addr_b = 13'h1FFF; din_b = 16'h1234;
    wait_ack(0, 1, cyc, ga, gb);
    ref_mem[13'h1FFF] = 16'h1234;
    last_win = SIDE_B;
    n_checks++; if (cyc !== 4 || {ga, gb} !== 2'b01) begin n_fail++; $display("FAIL wr_ack: got %0d cycles ack %b want 4 01", cyc, {ga, gb}); end
    n_checks++; if (dout_b0 !== exp_b || dout_a0 !== exp_a) begin n_fail++; $display("FAIL wr_dout: got %h/%h want %h/%h", dout_a0, dout_b0, exp_a, exp_b); end
    n_checks++; if (wren_cnt0 - w0 !== 1 || wren_addr0 !== 13'h1FFF || wren_data0 !== 16'h1234) begin n_fail++; $display("FAIL wr_strobe: cycles %0d addr %h data %h want 1 1fff 1234", wren_cnt0 - w0, wren_addr0, wren_data0); end
    we_b = 1'b0; din_b = DW'($urandom);
    wait_ack(0, 0, cyc, ga, gb);
    req_b = 1'b0;
    exp_b = ref_mem[13'h1FFF];
    n_checks++; if (cyc !== 4 || {ga, gb} !== 2'b01) begin n_fail++; $display("FAIL rb_ack: got %0d cycles ack %b want 4 01", cyc, {ga, gb}); end
    n_checks++; if (dout_b0 !== exp_b || dout_a0 !== exp_a) begin n_fail++; $display("FAIL rb_dout: got %h/%h want %h/%h", dout_a0, dout_b0, exp_a, exp_b); end
    @(negedge clock);
    n_checks++; if (ack_b0 !== 1'b0 || wren_cnt0 - w0 !== 1) begin n_fail++; $display("FAIL rb_after: ack %b wren cycles %0d want 0 1", ack_b0, wren_cnt0 - w0); end
  endtask

  task automatic test_round_robin();
    int cyc;
    logic ga, gb;
    bit win;
    logic [1:0] exp_g;
    do_reset();
    preload(13'h0100, DW'($urandom));
    preload(13'h0200, DW'($urandom));
    req_a = 1'b1; we_a = 1'b0; addr_a = 13'h0100;
    req_b = 1'b1; we_b = 1'b0; addr_b = 13'h0200;
    for (int k = 0; k < 8; k++) begin
      win = (last_win == SIDE_B) ? SIDE_A : SIDE_B;
      exp_g = (win == SIDE_A) ? 2'b10 : 2'b01;
      wait_ack(0, (k == 0) ? 1 : 0, cyc, ga, gb);
      if (k == 7) begin req_a = 1'b0; req_b = 1'b0; end
      if (win == SIDE_A) exp_a = ref_mem[13'h0100]; else exp_b = ref_mem[13'h0200];
      last_win = win;
      n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL rr_spacing[%0d]: got %0d want 4", k, cyc); end
      n_checks++; if ({ga, gb} !== exp_g) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", k, {ga, gb}, exp_g); end
      n_checks++; if (dout_a0 !== exp_a || dout_b0 !== exp_b) begin n_fail++; $display("FAIL rr_dout[%0d]: got %h/%h want %h/%h", k, dout_a0, dout_b0, exp_a, exp_b); end
    end
    @(negedge clock);
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rr_idle: busy %b want 0", busy0); end
  endtask

  task automatic test_fixed_priority();
    int cyc;
    logic ga, gb;
    logic [DW-1:0] va, vb;
    do_reset();
    va = DW'($urandom);
    vb = ~va;
    preload(13'h0400, va);
    preload(13'h0500, vb);
    req_a = 1'b1; we_a = 1'b0; addr_a = 13'h0400;
    req_b = 1'b1; we_b = 1'b0; addr_b = 13'h0500;
    for (int k = 0; k < 4; k++) begin
      wait_ack(1, (k == 0) ? 1 : 0, cyc, ga, gb);
      if (k == 3) req_a = 1'b0;
      n_checks++; if (cyc !== 4 || {ga, gb} !== 2'b10) begin n_fail++; $display("FAIL prio_a[%0d]: got %0d cycles ack %b want 4 10", k, cyc, {ga, gb}); end
      n_checks++; if (dout_a1 !== va || dout_b1 !== '0) begin n_fail++; $display("FAIL prio_dout[%0d]: got %h/%h want %h/0", k, dout_a1, dout_b1, va); end
    end
    wait_ack(1, 0, cyc, ga, gb);
    req_b = 1'b0;
    n_checks++; if (cyc !== 4 || {ga, gb} !== 2'b01) begin n_fail++; $display("FAIL prio_b: got %0d cycles ack %b want 4 01", cyc, {ga, gb}); end
    n_checks++; if (dout_b1 !== vb || dout_a1 !== va) begin n_fail++; $display("FAIL prio_b_dout: got %h/%h want %h/%h", dout_a1, dout_b1, va, vb); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_write();
    int cyc, n_ack;
    logic ga, gb;
    logic [DW-1:0] d;
    do_reset();
    d = DW'($urandom);
    req_a = 1'b1; we_a = 1'b1; addr_a = 13'h0005; din_a = d;
    @(negedge clock);
    n_checks++; if (ram_wren0 !== 1'b1 || ram_address0 !== 13'h0005) begin n_fail++; $display("FAIL rst_issue: wren %b addr %h want 1 0005", ram_wren0, ram_address0); end
    reset = 1'b1;
    @(negedge clock);
    n_checks++; if ({ram_wren0, busy0, ack_a0, ack_b0, ram_wren1, busy1, ack_a1, ack_b1} !== 8'b0) begin n_fail++; $display("FAIL rst_abort: got %b want 0", {ram_wren0, busy0, ack_a0, ack_b0, ram_wren1, busy1, ack_a1, ack_b1}); end
    reset = 1'b0;
    req_a = 1'b0;
    exp_a = '0; exp_b = '0; last_win = SIDE_B;
    ref_mem[13'h0005] = d;
    n_ack = 0;
    repeat (6) begin
      @(negedge clock);
      if (ack_a0 || ack_b0 || busy0) n_ack++;
    end
    n_checks++; if (n_ack !== 0) begin n_fail++; $display("FAIL rst_noack: got %0d active cycles want 0", n_ack); end
    req_a = 1'b1; we_a = 1'b0; addr_a = 13'h0005;
    wait_ack(0, 1, cyc, ga, gb);
    req_a = 1'b0;
    exp_a = ref_mem[13'h0005];
    last_win = SIDE_A;
    n_checks++; if (cyc !== 4 || {ga, gb} !== 2'b10) begin n_fail++; $display("FAIL rst_next: got %0d cycles ack %b want 4 10", cyc, {ga, gb}); end
    n_checks++; if (dout_a0 !== exp_a) begin n_fail++; $display("FAIL rst_next_dout: got %h want %h", dout_a0, exp_a); end
  endtask

  task automatic test_late_operand();
    int cyc;
    logic ga, gb;
    logic [DW-1:0] v1;
    v1 = DW'($urandom);
    preload(13'h0001, v1);
    preload(13'h0002, ~v1);
    req_a = 1'b1; we_a = 1'b0; addr_a = 13'h0001;
    @(negedge clock);
    @(negedge clock);
    addr_a = 13'h0002;
    wait_ack(0, 3, cyc, ga, gb);
    req_a = 1'b0;
    exp_a = ref_mem[13'h0001];
    last_win = SIDE_A;
    n_checks++; if (cyc !== 4 || {ga, gb} !== 2'b10) begin n_fail++; $display("FAIL late_ack: got %0d cycles ack %b want 4 10", cyc, {ga, gb}); end
    n_checks++; if (dout_a0 !== exp_a || dout_b0 !== exp_b) begin n_fail++; $display("FAIL late_dout: got %h/%h want %h/%h", dout_a0, dout_b0, exp_a, exp_b); end
    @(negedge clock);
  endtask

  task automatic test_random();
    int cyc, mode;
    logic ga, gb;
    bit pend_a, pend_b, win;
    logic [1:0] exp_g;
    do_reset();
    for (int i = 0; i < 64; i++) preload(AW'(13'h0300 + i), DW'($urandom));
    for (int t = 0; t < 40; t++) begin
      mode   = int'($urandom_range(1, 3));
      pend_a = (mode & 1) != 0;
      pend_b = (mode & 2) != 0;
      we_a = 1'($urandom); addr_a = AW'(13'h0300 + $urandom_range(0, 63)); din_a = DW'($urandom);
      we_b = 1'($urandom); addr_b = AW'(13'h0300 + $urandom_range(0, 63)); din_b = DW'($urandom);
      req_a = pend_a;
      req_b = pend_b;
      for (int s = 0; pend_a || pend_b; s++) begin
        if (pend_a && pend_b) win = (last_win == SIDE_B) ? SIDE_A : SIDE_B;
        else                  win = pend_a ? SIDE_A : SIDE_B;
        exp_g = (win == SIDE_A) ? 2'b10 : 2'b01;
        wait_ack(0, (s == 0) ? 1 : 0, cyc, ga, gb);
        if (win == SIDE_A) begin
          req_a = 1'b0; pend_a = 1'b0;
          if (we_a) ref_mem[addr_a] = din_a; else exp_a = ref_mem[addr_a];
        end else begin
          req_b = 1'b0; pend_b = 1'b0;
          if (we_b) ref_mem[addr_b] = din_b; else exp_b = ref_mem[addr_b];
        end
        last_win = win;
        n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL rnd_latency[%0d.%0d]: got %0d want 4", t, s, cyc); end
        n_checks++; if ({ga, gb} !== exp_g) begin n_fail++; $display("FAIL rnd_grant[%0d.%0d]: got %b want %b", t, s, {ga, gb}, exp_g); end
        n_checks++; if (dout_a0 !== exp_a || dout_b0 !== exp_b) begin n_fail++; $display("FAIL rnd_dout[%0d.%0d]: got %h/%h want %h/%h", t, s, dout_a0, dout_b0, exp_a, exp_b); end
      end
      repeat (1 + $urandom_range(0, 2)) @(negedge clock);
    end
  endtask

  initial begin
    reset  = 1'b1;
    req_a  = 1'b0; we_a = 1'b0; addr_a = '0; din_a = '0;
    req_b  = 1'b0; we_b = 1'b0; addr_b = '0; din_b = '0;
    pre_en = 1'b0; pre_addr = '0; pre_val = '0;
    test_reset();
    test_single_read();
    test_write_read();
    test_round_robin();
    test_fixed_priority();
    test_reset_mid_write();
    test_late_operand();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
